// File: rtl/spi_reg_ctrl_if.sv
// Requester-side bus of spi_reg_ctrl: one request in, one response out.
// The master modport is the requester; the slave modport is the controller.
interface spi_reg_ctrl_if #(
  parameter int DATA_BYTES = 2,
  parameter int SLAVE_NUM  = 2
);
  localparam int SW = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [6:0]              req_addr;
  logic [8*DATA_BYTES-1:0] req_wdata;
  logic [SW-1:0]           req_slave;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [8*DATA_BYTES-1:0] rsp_rdata;
  logic                    rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_slave, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_slave, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Register-access framer in front of axis_spi_master: sends {rd,addr,data...}
// as one tlast-terminated frame and collects the echoed bytes as read data.
module spi_reg_ctrl #(
  parameter int  DATA_BYTES  = 2,
  parameter int  SLAVE_NUM   = 2,
  parameter int  TIMEOUT_CYC = 4096,
  localparam int SW          = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1
) (
  input  logic          clk_i,
  input  logic          arstn_i,
  spi_reg_ctrl_if.slave bus,
  output logic [SW-1:0] spi_addr,
  output logic [7:0]    m_axis_tdata,
  output logic          m_axis_tvalid,
  output logic          m_axis_tlast,
  input  logic          m_axis_tready,
  input  logic [7:0]    s_axis_tdata,
  input  logic          s_axis_tvalid,
  input  logic          s_axis_tlast,
  output logic          s_axis_tready
);
  localparam int N  = DATA_BYTES + 1;
  localparam int NW = 8 * N;
  localparam int DW = 8 * DATA_BYTES;
  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CW-1:0] CNT_N    = CW'(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SEND    = 2'd1;
  localparam logic [1:0] WAIT_RX = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]    state_reg, state_next;
  logic [NW-1:0] tx_buf_reg, tx_buf_next;
  logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
  logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
  logic [DW-1:0] rdata_reg, rdata_next;
  logic          err_reg, err_next;
  logic [SW-1:0] slave_reg, slave_next;
  logic [TW-1:0] tmo_reg, tmo_next;

  logic          busy, tx_hs, rx_hs, tx_last;
  logic [DW+7:0] shift_tmp;

  assign busy      = (state_reg == SEND) || (state_reg == WAIT_RX);
  assign tx_last   = (tx_cnt_reg == CNT_LAST);
  assign tx_hs     = (state_reg == SEND) && m_axis_tready;
  assign rx_hs     = s_axis_tvalid && s_axis_tready;
  assign shift_tmp = {rdata_reg, s_axis_tdata};

  // IDLE keeps accepting so stray echo bytes left over from an aborted frame drain away.
  assign s_axis_tready = (state_reg == IDLE) || (busy && (rx_cnt_reg != CNT_N));

  assign m_axis_tvalid = (state_reg == SEND);
  assign m_axis_tdata  = tx_buf_reg[NW-1 -: 8];
  assign m_axis_tlast  = (state_reg == SEND) && tx_last;

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_rdata = rdata_reg;
  assign bus.rsp_err   = err_reg;
  assign spi_addr      = slave_reg;

  always_comb begin
    state_next  = state_reg;
    tx_buf_next = tx_buf_reg;
    tx_cnt_next = tx_cnt_reg;
    rx_cnt_next = rx_cnt_reg;
    rdata_next  = rdata_reg;
    err_next    = err_reg;
    slave_next  = slave_reg;
    tmo_next    = tmo_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          state_next  = SEND;
          tx_buf_next = {~bus.req_we, bus.req_addr, bus.req_we ? bus.req_wdata : {DW{1'b0}}};
          tx_cnt_next = '0;
          rx_cnt_next = '0;
          rdata_next  = '0;
          err_next    = 1'b0;
          slave_next  = bus.req_slave;
          tmo_next    = '0;
        end
      end
      SEND, WAIT_RX: begin
        if (tx_hs) begin
          tx_buf_next = tx_buf_reg << 8;
          tx_cnt_next = tx_cnt_reg + CNT_ONE;
        end
        if (rx_hs) begin
          rx_cnt_next = rx_cnt_reg + CNT_ONE;
          // The echo of the address byte carries no data.
          if (rx_cnt_reg != '0)
            rdata_next = shift_tmp[DW-1:0];
          if (s_axis_tlast != (rx_cnt_reg == CNT_LAST))
            err_next = 1'b1;
        end
        tmo_next = (tx_hs || rx_hs) ? '0 : tmo_reg + TMO_ONE;
        if (!tx_hs && !rx_hs && (tmo_reg == TMO_MAX)) begin
          state_next = RESP;
          err_next   = 1'b1;
        end else if (((state_reg == WAIT_RX) || (tx_hs && tx_last)) && (rx_cnt_next == CNT_N)) begin
          state_next = RESP;
        end else if (tx_hs && tx_last) begin
          state_next = WAIT_RX;
        end
      end
      RESP: begin
        if (bus.rsp_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_reg  <= IDLE;
      tx_buf_reg <= '0;
      tx_cnt_reg <= '0;
      rx_cnt_reg <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
      slave_reg  <= '0;
      tmo_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      tx_buf_reg <= tx_buf_next;
      tx_cnt_reg <= tx_cnt_next;
      rx_cnt_reg <= rx_cnt_next;
      rdata_reg  <= rdata_next;
      err_reg    <= err_next;
      slave_reg  <= slave_next;
      tmo_reg    <= tmo_next;
    end
  end
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: transaction-level model checked every cycle plus
// literal expectations for the directed register-access vectors.
module tb_spi_reg_ctrl;
  localparam int DB  = 2;
  localparam int SN  = 2;
  localparam int TMO = 64;
  localparam int N   = DB + 1;
  localparam int DW  = 8 * DB;

  logic       clk, arstn;
  logic [0:0] spi_addr;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tlast, m_tready;
  logic [7:0] s_tdata;
  logic       s_tvalid, s_tlast, s_tready;

  int checks = 0;
  int errors = 0;

  spi_reg_ctrl_if #(.DATA_BYTES(DB), .SLAVE_NUM(SN)) bus ();

  spi_reg_ctrl #(.DATA_BYTES(DB), .SLAVE_NUM(SN), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .arstn_i(arstn), .bus(bus), .spi_addr(spi_addr),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one outstanding request, frame bytes, echo bytes, idle timer.
  logic          busy = 1'b0, resp_exp = 1'b0;
  logic [7:0]    frame [N];
  int            tx_idx = 0, rx_idx = 0, idle = 0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_err = 1'b0;
  logic [0:0]    m_slave = '0;
  logic [8:0]    tx_log [$];

  always @(negedge clk) begin
    logic exp_tvalid, exp_stready, tx_hs, rx_hs;
    #2;
    if (!arstn) begin
      busy = 1'b0;
      resp_exp = 1'b0;
    end else begin
      exp_tvalid  = busy && !resp_exp && (tx_idx < N);
      exp_stready = !busy || (!resp_exp && (rx_idx < N));
      chk("tvalid", m_tvalid, exp_tvalid);
      if (exp_tvalid) begin
        chk("tdata", m_tdata, frame[tx_idx]);
        chk("tlast", m_tlast, tx_idx == N - 1);
      end
      chk("req_ready", bus.req_ready, !busy);
      chk("rsp_valid", bus.rsp_valid, resp_exp);
      if (resp_exp) begin
        chk("rsp_rdata", bus.rsp_rdata, m_rdata);
        chk("rsp_err", bus.rsp_err, m_err);
      end
      if (busy) chk("spi_addr", spi_addr, m_slave);
      if (!resp_exp) chk("s_tready", s_tready, exp_stready);

      tx_hs = exp_tvalid && m_tready;
      rx_hs = s_tvalid && exp_stready;
      if (tx_hs) tx_log.push_back({m_tlast, m_tdata});
      if (!busy) begin
        if (bus.req_valid) begin
          busy = 1'b1;
          frame[0] = {~bus.req_we, bus.req_addr};
          for (int k = 1; k < N; k++)
            frame[k] = bus.req_we ? bus.req_wdata[8*(DB-k) +: 8] : 8'h00;
          tx_idx = 0; rx_idx = 0; idle = 0;
          m_rdata = '0; m_err = 1'b0; m_slave = bus.req_slave;
        end
      end else if (resp_exp) begin
        if (bus.rsp_ready) begin
          busy = 1'b0;
          resp_exp = 1'b0;
        end
      end else begin
        if (tx_hs) tx_idx++;
        if (rx_hs) begin
          if (rx_idx > 0) m_rdata = {m_rdata[DW-9:0], s_tdata};
          if (s_tlast != (rx_idx == N - 1)) m_err = 1'b1;
          rx_idx++;
        end
        idle = (tx_hs || rx_hs) ? 0 : idle + 1;
        if (tx_idx == N && rx_idx == N) resp_exp = 1'b1;
        else if (idle == TMO) begin
          resp_exp = 1'b1;
          m_err = 1'b1;
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [6:0] addr, input logic [DW-1:0] wdata,
                        input logic [0:0] slave);
    tx_log.delete();
    @(negedge clk);
    bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata; bus.req_slave = slave;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 200 && !bus.req_ready; i++) @(negedge clk);
    chk("req_accept_wait", bus.req_ready, 1'b1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic l);
    @(negedge clk);
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    for (int i = 0; i < 200 && !s_tready; i++) @(negedge clk);
    chk("rx_accept_wait", s_tready, 1'b1);
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic finish_rsp(input int hold, output logic [DW-1:0] rdata, output logic err);
    for (int i = 0; i < 500 && !bus.rsp_valid; i++) @(negedge clk);
    chk("rsp_wait", bus.rsp_valid, 1'b1);
    for (int i = 0; i < hold; i++) begin
      chk("hold_rsp_valid", bus.rsp_valid, 1'b1);
      chk("hold_req_ready", bus.req_ready, 1'b0);
      @(negedge clk);
    end
    rdata = bus.rsp_rdata;
    err = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic check_tx(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [8:0] exp [3];
    exp[0] = {1'b0, b0}; exp[1] = {1'b0, b1}; exp[2] = {1'b1, b2};
    chk("tx_count", tx_log.size(), 3);
    for (int i = 0; i < 3 && i < tx_log.size(); i++) chk("tx_byte", tx_log[i], exp[i]);
  endtask

  logic [DW-1:0] rd;
  logic          er;

  initial begin
    arstn = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_slave = '0; bus.rsp_ready = 1'b0;
    m_tready = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0;
    #1 arstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_spi_addr", spi_addr, 1'b0);
    arstn = 1'b1;

    do_req(1'b1, 7'h05, 16'hBEEF, 1'b1);
    rx_byte(8'h00, 1'b0); rx_byte(8'h00, 1'b0); rx_byte(8'h00, 1'b1);
    finish_rsp(0, rd, er);
    check_tx(8'h05, 8'hBE, 8'hEF);
    chk("w_err", er, 1'b0);
    $display("txn write addr=05 wdata=BEEF err=%0d", er);

    do_req(1'b0, 7'h2A, 16'h0000, 1'b0);
    rx_byte(8'hFF, 1'b0); rx_byte(8'h12, 1'b0); rx_byte(8'h34, 1'b1);
    finish_rsp(0, rd, er);
    check_tx(8'hAA, 8'h00, 8'h00);
    chk("r_rdata", rd, 16'h1234);
    chk("r_err", er, 1'b0);
    $display("txn read addr=2A rdata=%04h err=%0d", rd, er);

    do_req(1'b1, 7'h7F, 16'hA55A, 1'b1);
    fork
      begin
        for (int i = 0; i < 100 && tx_log.size() < 1; i++) @(negedge clk);
        m_tready = 1'b0;
        repeat (20) @(negedge clk);
        m_tready = 1'b1;
      end
      begin
        rx_byte(8'h01, 1'b0); rx_byte(8'h02, 1'b0); rx_byte(8'h03, 1'b1);
      end
    join
    finish_rsp(0, rd, er);
    check_tx(8'h7F, 8'hA5, 8'h5A);
    chk("stall_rdata", rd, 16'h0203);
    $display("txn stalled write addr=7F wdata=A55A err=%0d", er);

    do_req(1'b0, 7'h10, 16'h0000, 1'b0);
    rx_byte(8'h11, 1'b0); rx_byte(8'h22, 1'b0);
    for (int i = 0; i < 500 && !bus.rsp_valid; i++) @(negedge clk);
    chk("tmo_tvalid", m_tvalid, 1'b0);
    finish_rsp(0, rd, er);
    chk("tmo_err", er, 1'b1);
    chk("tmo_rdata", rd, 16'h0022);
    $display("txn timeout read addr=10 rdata=%04h err=%0d", rd, er);

    do_req(1'b0, 7'h01, 16'h0000, 1'b1);
    rx_byte(8'hAB, 1'b0); rx_byte(8'hCD, 1'b1); rx_byte(8'hEF, 1'b0);
    finish_rsp(10, rd, er);
    chk("frm_err", er, 1'b1);
    chk("frm_rdata", rd, 16'hCDEF);
    $display("txn framing read addr=01 rdata=%04h err=%0d", rd, er);

    do_req(1'b1, 7'h44, 16'h1357, 1'b1);
    rx_byte(8'h00, 1'b0);
    @(negedge clk);
    arstn = 1'b0;
    #1;
    chk("arst_req_ready", bus.req_ready, 1'b1);
    chk("arst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("arst_tvalid", m_tvalid, 1'b0);
    chk("arst_tlast", m_tlast, 1'b0);
    chk("arst_spi_addr", spi_addr, 1'b0);
    chk("arst_rdata", bus.rsp_rdata, 16'h0000);
    chk("arst_err", bus.rsp_err, 1'b0);
    repeat (3) @(negedge clk);
    arstn = 1'b1;
    $display("txn async reset during send");
    rx_byte(8'h77, 1'b0); rx_byte(8'h88, 1'b1);

    do_req(1'b0, 7'h33, 16'h0000, 1'b0);
    rx_byte(8'h00, 1'b0); rx_byte(8'h9A, 1'b0); rx_byte(8'hBC, 1'b1);
    finish_rsp(0, rd, er);
    check_tx(8'hB3, 8'h00, 8'h00);
    chk("post_rst_rdata", rd, 16'h9ABC);
    chk("post_rst_err", er, 1'b0);
    $display("txn read after reset addr=33 rdata=%04h err=%0d", rd, er);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
